ysyx_25020037_lsu: RTL and testbench

- Load/store unit of the multi-cycle core. It consumes the EXU→LSU handshake and bus (result = address or ALU value, src2 = store data).
- For memory instructions it issues one AXI4-Lite master transaction. It then presents writeback data to the WBU through a valid/ready handshake.
- Non-memory instructions pass through with no bus activity.

---
 rtl/ysyx_25020037_lsu_pkg.sv | 16 +
 rtl/ysyx_25020037_lsu_if.sv | 62 ++++++
 rtl/ysyx_25020037_lsu_align.sv | 49 ++++
 rtl/ysyx_25020037_lsu.sv | 172 +++++++++++++++++
 tb/tb_ysyx_25020037_lsu.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared definitions for the load/store unit: bus widths, funct3 size codes,
// and the AXI response code treated as success.
package ysyx_25020037_lsu_pkg;

    localparam int EU_TO_LU_BUS_WD = 64;  // {result[31:0], src2[31:0]}
    localparam int LU_TO_WU_BUS_WD = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25020037_lsu_if.sv
// Bundle of every non-clock signal around the LSU: EXU handshake and bus,
// AXI4-Lite master channels, and WBU handshake.
//   master : LSU view (drives lsu_ready, AXI valids/addr/data, writeback)
//   slave  : environment view (EXU, memory slave, WBU)
interface ysyx_25020037_lsu_if;
    import ysyx_25020037_lsu_pkg::*;

    logic                       exu_valid;
    logic                       lsu_ready;
    logic                       inst_l;
    logic                       inst_s;
    logic [2:0]                 mem_funct3;
    logic [EU_TO_LU_BUS_WD-1:0] eu_to_lu_bus;

    logic [31:0]                araddr;
    logic                       arvalid;
    logic                       arready;
    logic [31:0]                rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;
    logic [31:0]                awaddr;
    logic                       awvalid;
    logic                       awready;
    logic [31:0]                wdata;
    logic [3:0]                 wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;

    logic                       lsu_valid;
    logic                       wbu_ready;
    logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus;
    logic                       lsu_err;

    modport master (
        input  exu_valid, inst_l, inst_s, mem_funct3, eu_to_lu_bus,
        output lsu_ready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output lsu_valid, lu_to_wu_bus, lsu_err,
        input  wbu_ready
    );

    modport slave (
        output exu_valid, inst_l, inst_s, mem_funct3, eu_to_lu_bus,
        input  lsu_ready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  lsu_valid, lu_to_wu_bus, lsu_err,
        output wbu_ready
    );

endinterface

// File: rtl/ysyx_25020037_lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   funct3, addr_lo : access size/sign and low address bits
//   rdata           : raw 32-bit read beat -> load_data (extracted, extended)
//   src2            : store operand        -> store_data (lane replicated), store_strb
//   misaligned      : half not on 2-byte or word not on 4-byte boundary
module ysyx_25020037_lsu_align
    import ysyx_25020037_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] src2,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  store_strb,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        store_data = src2;
        store_strb = 4'b1111;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                // funct3[2] marks the unsigned variants
                load_data  = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
                store_data = {4{src2[7:0]}};
                store_strb = 4'b0001 << addr_lo;
            end
            F3_H, F3_HU: begin
                load_data  = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
                store_data = {2{src2[15:0]}};
                store_strb = 4'b0011 << {addr_lo[1], 1'b0};
                misaligned = addr_lo[0];
            end
            default: begin
                // F3_W and unused codes behave as a full word
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit: takes one op from the EXU, performs at most one AXI4-Lite
// transaction, and hands the writeback value to the WBU.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : EXU handshake/bus, AXI4-Lite master channels, WBU handshake
//
// state | meaning
// IDLE  | lsu_ready high, waiting for exu_valid
// RD_A  | read address channel valid
// RD_D  | waiting for read data
// WR    | write address and data channels valid, each drops on its own ready
// WR_B  | waiting for write response
// DONE  | lsu_valid high, holding data/err until wbu_ready
module ysyx_25020037_lsu
    import ysyx_25020037_lsu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ysyx_25020037_lsu_if.master  bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_D = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_WR_B = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        RD_A = ST_RD_A,
        RD_D = ST_RD_D,
        WR   = ST_WR,
        WR_B = ST_WR_B,
        DONE = ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [31:0] src2_q, src2_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [LU_TO_WU_BUS_WD-1:0] data_q, data_d;
    logic        err_q, err_d;

    logic        capture;
    logic        aw_fin;
    logic        w_fin;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  store_strb;
    logic        misaligned;

    // The aligner sees the incoming op on the capture cycle so misalignment
    // can be decided before any bus request; afterwards d equals q.
    always_comb begin
        capture  = (state_q == IDLE) && bus.exu_valid;
        result_d = capture ? bus.eu_to_lu_bus[EU_TO_LU_BUS_WD-1 -: 32] : result_q;
        src2_d   = capture ? bus.eu_to_lu_bus[31:0]                    : src2_q;
        funct3_d = capture ? bus.mem_funct3                            : funct3_q;
    end

    ysyx_25020037_lsu_align u_align (
        .funct3     (funct3_d),
        .addr_lo    (result_d[1:0]),
        .rdata      (bus.rdata),
        .src2       (src2_d),
        .load_data  (load_data),
        .store_data (store_data),
        .store_strb (store_strb),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            src2_q    <= '0;
            funct3_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            src2_q    <= src2_d;
            funct3_q  <= funct3_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    // A channel counts as finished if it already handshook or does so now,
    // so simultaneous AW/W readiness moves to WR_B without an extra cycle.
    assign aw_fin = aw_done_q | bus.awready;
    assign w_fin  = w_done_q  | bus.wready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        data_d    = data_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (bus.exu_valid) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    data_d    = result_d;
                    if (bus.inst_l || bus.inst_s) begin
                        if (misaligned) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                            data_d  = '0;
                        end else begin
                            state_d = bus.inst_l ? RD_A : WR;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_A: begin
                if (bus.arready) state_d = RD_D;
            end
            RD_D: begin
                if (bus.rvalid) begin
                    state_d = DONE;
                    err_d   = (bus.rresp != AXI_RESP_OKAY);
                    data_d  = (bus.rresp != AXI_RESP_OKAY) ? '0 : load_data;
                end
            end
            WR: begin
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) state_d = WR_B;
            end
            WR_B: begin
                if (bus.bvalid) begin
                    state_d = DONE;
                    err_d   = (bus.bresp != AXI_RESP_OKAY);
                    data_d  = result_q;
                end
            end
            DONE: begin
                if (bus.wbu_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.lsu_ready    = (state_q == IDLE);
        bus.arvalid      = (state_q == RD_A);
        bus.araddr       = (state_q == RD_A) ? {result_q[31:2], 2'b00} : 32'h0;
        bus.rready       = (state_q == RD_D);
        bus.awvalid      = (state_q == WR) && !aw_done_q;
        bus.wvalid       = (state_q == WR) && !w_done_q;
        bus.awaddr       = (state_q == WR) ? {result_q[31:2], 2'b00} : 32'h0;
        bus.wdata        = (state_q == WR) ? store_data : 32'h0;
        bus.wstrb        = (state_q == WR) ? store_strb : 4'h0;
        bus.bready       = (state_q == WR_B);
        bus.lsu_valid    = (state_q == DONE);
        bus.lu_to_wu_bus = data_q;
        bus.lsu_err      = (state_q == DONE) && err_q;
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
module tb_ysyx_25020037_lsu;
    import ysyx_25020037_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25020037_lsu_if lif();
    ysyx_25020037_lsu dut (.clk(clk), .rst(rst), .bus(lif));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [31:0] mem_rdata = 32'h0;
    logic [1:0]  mem_rresp = 2'b00;
    logic [1:0]  mem_bresp = 2'b00;
    logic        r_stall   = 1'b0;
    logic        r_pend, aw_seen, w_seen;
    logic        aw_hs, w_hs;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    logic [31:0] last_araddr = 0, last_awaddr = 0, last_wdata = 0;
    logic [3:0]  last_wstrb = 0;

    assign aw_hs = lif.awvalid & lif.awready;
    assign w_hs  = lif.wvalid & lif.wready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lif.rvalid <= 1'b0;
            lif.rdata  <= 32'h0;
            lif.rresp  <= 2'b00;
            lif.bvalid <= 1'b0;
            lif.bresp  <= 2'b00;
            r_pend     <= 1'b0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
        end else begin
            if (lif.rvalid && lif.rready) lif.rvalid <= 1'b0;
            if (r_pend && !r_stall) begin
                lif.rvalid <= 1'b1;
                r_pend     <= 1'b0;
            end
            if (lif.arvalid && lif.arready) begin
                lif.rdata <= mem_rdata;
                lif.rresp <= mem_rresp;
                if (r_stall) r_pend <= 1'b1;
                else         lif.rvalid <= 1'b1;
            end
            if (lif.bvalid && lif.bready) lif.bvalid <= 1'b0;
            if ((aw_seen | aw_hs) && (w_seen | w_hs)) begin
                lif.bvalid <= 1'b1;
                lif.bresp  <= mem_bresp;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end else begin
                aw_seen <= aw_seen | aw_hs;
                w_seen  <= w_seen | w_hs;
            end
        end
    end

    always @(posedge clk) begin
        if (lif.arvalid && lif.arready) begin
            ar_cnt      <= ar_cnt + 1;
            last_araddr <= lif.araddr;
        end
        if (aw_hs) begin
            aw_cnt      <= aw_cnt + 1;
            last_awaddr <= lif.awaddr;
        end
        if (w_hs) begin
            w_cnt      <= w_cnt + 1;
            last_wdata <= lif.wdata;
            last_wstrb <= lif.wstrb;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;   // negative: not checked
        int          cap;
    } exp_t;
    exp_t sb_q[$];

    always begin : monitor
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                seen = 1'b0;
            end else if (lif.lsu_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_beat: got lsu_valid=1 data=%h want no beat", lif.lu_to_wu_bus);
                end else begin
                    if (!seen && sb_q[0].lat >= 0)
                        check32("latency", 32'(cyc - sb_q[0].cap), 32'(sb_q[0].lat));
                    seen = 1'b1;
                    if (lif.wbu_ready) begin
                        check32("wb_data", lif.lu_to_wu_bus, sb_q[0].data);
                        check32("wb_err", 32'(lif.lsu_err), 32'(sb_q[0].err));
                        void'(sb_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        l;
        logic        s;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] src2;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
        int          e_rd;
        int          e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic drive(input vec_t v, input logic push, input int lat);
        @(negedge clk);
        mem_rdata        = v.rdata;
        mem_rresp        = v.resp;
        mem_bresp        = v.resp;
        lif.exu_valid    = 1'b1;
        lif.inst_l       = v.l;
        lif.inst_s       = v.s;
        lif.mem_funct3   = v.f3;
        lif.eu_to_lu_bus = {v.res, v.src2};
        if (push) sb_q.push_back('{v.e_data, v.e_err, lat, cyc});
        @(negedge clk);
        lif.exu_valid    = 1'b0;
        lif.inst_l       = 1'b0;
        lif.inst_s       = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending beats want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int ar0, aw0, w0;
        v   = vecs[idx];
        ar0 = ar_cnt;
        aw0 = aw_cnt;
        w0  = w_cnt;
        drive(v, 1'b1, v.e_lat);
        drain($sformatf("vec%0d", idx));
        check32($sformatf("vec%0d_ar_count", idx), 32'(ar_cnt - ar0), 32'(v.e_rd));
        check32($sformatf("vec%0d_aw_count", idx), 32'(aw_cnt - aw0), 32'(v.e_wr));
        check32($sformatf("vec%0d_w_count", idx), 32'(w_cnt - w0), 32'(v.e_wr));
        if (v.e_rd != 0) check32($sformatf("vec%0d_araddr", idx), last_araddr, v.e_addr);
        if (v.e_wr != 0) begin
            check32($sformatf("vec%0d_awaddr", idx), last_awaddr, v.e_addr);
            check32($sformatf("vec%0d_wdata", idx), last_wdata, v.e_wdata);
            check32($sformatf("vec%0d_wstrb", idx), 32'(last_wstrb), 32'(v.e_strb));
        end
    endtask

    task automatic check_reset(input string tag);
        check32({tag, "_valids"},
                32'({lif.lsu_ready, lif.arvalid, lif.rready, lif.awvalid, lif.wvalid,
                     lif.bready, lif.lsu_valid, lif.lsu_err}), 32'h80);
        check32({tag, "_araddr"}, lif.araddr, 32'h0);
        check32({tag, "_awaddr"}, lif.awaddr, 32'h0);
        check32({tag, "_wdata"}, lif.wdata, 32'h0);
        check32({tag, "_wstrb"}, 32'(lif.wstrb), 32'h0);
    endtask

    initial begin
        vec_t v;
        //          l     s     f3      res           src2          rdata         resp   e_data        err  lat rd wr e_addr        e_wdata       strb
        vecs[0]  = '{1'b1, 1'b0, F3_W,  32'h80000004, 32'h0,        32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h80000004, 32'h0,        4'h0};
        vecs[1]  = '{1'b1, 1'b0, F3_B,  32'h80000003, 32'h0,        32'h80123456, 2'b00, 32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[2]  = '{1'b1, 1'b0, F3_BU, 32'h80000003, 32'h0,        32'h80123456, 2'b00, 32'h00000080, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[3]  = '{1'b1, 1'b0, F3_HU, 32'h80000002, 32'h0,        32'h80123456, 2'b00, 32'h00008012, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[4]  = '{1'b1, 1'b0, F3_H,  32'h80000002, 32'h0,        32'h80123456, 2'b00, 32'hFFFF8012, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[5]  = '{1'b1, 1'b0, F3_B,  32'h80000001, 32'h0,        32'h80123456, 2'b00, 32'h00000034, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[6]  = '{1'b1, 1'b0, F3_W,  32'h80000008, 32'h0,        32'h12345678, 2'b10, 32'h00000000, 1'b1, 3, 1, 0, 32'h80000008, 32'h0,        4'h0};
        vecs[7]  = '{1'b0, 1'b1, F3_W,  32'h80000010, 32'hCAFEF00D, 32'h0,        2'b00, 32'h80000010, 1'b0, 3, 0, 1, 32'h80000010, 32'hCAFEF00D, 4'hF};
        vecs[8]  = '{1'b0, 1'b1, F3_B,  32'h80000005, 32'h000000A5, 32'h0,        2'b00, 32'h80000005, 1'b0, 3, 0, 1, 32'h80000004, 32'hA5A5A5A5, 4'h2};
        vecs[9]  = '{1'b0, 1'b1, F3_H,  32'h80000002, 32'h1234ABCD, 32'h0,        2'b00, 32'h80000002, 1'b0, 3, 0, 1, 32'h80000000, 32'hABCDABCD, 4'hC};
        vecs[10] = '{1'b0, 1'b1, F3_H,  32'h80000002, 32'h1234ABCD, 32'h0,        2'b10, 32'h80000002, 1'b1, 3, 0, 1, 32'h80000000, 32'hABCDABCD, 4'hC};
        vecs[11] = '{1'b0, 1'b0, F3_B,  32'h00000042, 32'h0,        32'h0,        2'b00, 32'h00000042, 1'b0, 1, 0, 0, 32'h0,        32'h0,        4'h0};
        vecs[12] = '{1'b1, 1'b0, F3_W,  32'h80000001, 32'h0,        32'hFFFFFFFF, 2'b00, 32'h00000000, 1'b1, 1, 0, 0, 32'h0,        32'h0,        4'h0};
        vecs[13] = '{1'b1, 1'b0, F3_H,  32'h80000003, 32'h0,        32'hFFFFFFFF, 2'b00, 32'h00000000, 1'b1, 1, 0, 0, 32'h0,        32'h0,        4'h0};
        vecs[14] = '{1'b0, 1'b1, F3_W,  32'h80000002, 32'h55555555, 32'h0,        2'b00, 32'h00000000, 1'b1, 1, 0, 0, 32'h0,        32'h0,        4'h0};
        vecs[15] = '{1'b1, 1'b1, F3_W,  32'h80000000, 32'h99999999, 32'h11223344, 2'b00, 32'h11223344, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[16] = '{1'b1, 1'b0, F3_HU, 32'h80000000, 32'h0,        32'h80123456, 2'b00, 32'h00003456, 1'b0, 3, 1, 0, 32'h80000000, 32'h0,        4'h0};
        vecs[17] = '{1'b0, 1'b1, F3_B,  32'h80000003, 32'hFFFFFF12, 32'h0,        2'b00, 32'h80000003, 1'b0, 3, 0, 1, 32'h80000000, 32'h12121212, 4'h8};

        lif.exu_valid    = 1'b0;
        lif.inst_l       = 1'b0;
        lif.inst_s       = 1'b0;
        lif.mem_funct3   = 3'b000;
        lif.eu_to_lu_bus = '0;
        lif.arready      = 1'b1;
        lif.awready      = 1'b1;
        lif.wready       = 1'b1;
        lif.wbu_ready    = 1'b1;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // sh with AW ready in cycle 1 and W ready in cycle 3
        v = vecs[9];
        lif.awready = 1'b0;
        lif.wready  = 1'b0;
        drive(v, 1'b1, -1);
        check32("split_c1_valids", 32'({lif.awvalid, lif.wvalid}), 32'h3);
        check32("split_c1_awaddr", lif.awaddr, 32'h80000000);
        check32("split_c1_wdata", lif.wdata, 32'hABCDABCD);
        check32("split_c1_wstrb", 32'(lif.wstrb), 32'hC);
        lif.awready = 1'b1;
        @(negedge clk);
        check32("split_c2_valids", 32'({lif.awvalid, lif.wvalid, lif.bready}), 32'h2);
        lif.awready = 1'b0;
        @(negedge clk);
        check32("split_c3_valids", 32'({lif.awvalid, lif.wvalid, lif.bready}), 32'h2);
        lif.wready = 1'b1;
        @(negedge clk);
        check32("split_c4_valids", 32'({lif.awvalid, lif.wvalid, lif.bready}), 32'h1);
        lif.awready = 1'b1;
        drain("split");

        // non-memory op held by wbu_ready = 0 for four cycles
        v = vecs[11];
        lif.wbu_ready = 1'b0;
        drive(v, 1'b1, 1);
        for (int k = 0; k < 4; k++) begin
            check32($sformatf("hold%0d_ctl", k),
                    32'({lif.lsu_valid, lif.lsu_ready, lif.arvalid, lif.awvalid, lif.wvalid}), 32'h10);
            check32($sformatf("hold%0d_data", k), lif.lu_to_wu_bus, 32'h00000042);
            if (k < 3) @(negedge clk);
        end
        lif.wbu_ready = 1'b1;
        drain("hold");
        check32("hold_release", 32'({lif.lsu_valid, lif.lsu_ready}), 32'h1);

        // reset while RD_D waits on a stalled read
        v = vecs[0];
        r_stall = 1'b1;
        drive(v, 1'b0, -1);
        @(negedge clk);
        check32("abort_in_rd_d", 32'({lif.rready, lif.lsu_ready}), 32'h2);
        rst = 1'b1;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst     = 1'b0;
        r_stall = 1'b0;
        run_vec(0);
        run_vec(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t want completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
